// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART framing FSM, serializer and output mux, one bit per CLK
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  Par_Bit,
  output logic                  TX_OUT,
  output logic                  BUSY
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [CW-1:0] cnt, cnt_n;
  logic par_en_q, par_en_n, tx_n, busy_n, last;
  assign last = cnt == CW'(DATA_WIDTH - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
      cnt      <= '0;
      shift    <= '0;
      par_en_q <= 1'b0;
    end else begin
      state    <= state_n;
      TX_OUT   <= tx_n;
      BUSY     <= busy_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      par_en_q <= par_en_n;
    end
  end
  // state names the bit currently on the line; each edge loads the following one
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    cnt_n    = cnt;
    par_en_n = par_en_q;
    tx_n     = TX_OUT;
    busy_n   = BUSY;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = Data_Valid;
        if (Data_Valid) begin
          state_n  = START;
          shift_n  = P_DATA;
          par_en_n = PAR_EN;
          tx_n     = 1'b0;
        end
      end
      START: begin
        state_n = DATA;
        tx_n    = shift[0];
        cnt_n   = '0;
      end
      DATA: begin
        if (last) begin
          state_n = par_en_q ? PARITY : STOP;
          tx_n    = par_en_q ? Par_Bit : 1'b1;
        end else begin
          shift_n = shift >> 1;
          tx_n    = shift_n[0];
          cnt_n   = cnt + CW'(1);
        end
      end
      PARITY: begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: directed frames plus random traffic against a frame-position model
module tb_uart_tx_frame_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst, dv, pe, pb, tx, busy;
  logic [W-1:0] pd;
  int checks = 0, errors = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .P_DATA(pd), .Data_Valid(dv), .PAR_EN(pe),
    .Par_Bit(pb), .TX_OUT(tx), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // model: position k within the frame decides the line value
  logic m_ok = 1'b0, m_act = 1'b0, m_p = 1'b0, e_tx = 1'b1, e_busy = 1'b0;
  logic [W-1:0] m_d;
  int m_k = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_act = 1'b0; e_tx = 1'b1; e_busy = 1'b0;
    end else if (!m_act) begin
      e_busy = dv;
      e_tx = !dv;
      if (dv) begin
        m_d = pd; m_p = pe; m_k = 0; m_act = 1'b1;
      end
    end else begin
      m_k++;
      if (m_k == W + 2 + int'(m_p)) begin
        m_act = 1'b0; e_tx = 1'b1; e_busy = 1'b0;
      end else begin
        e_busy = 1'b1;
        e_tx = m_k <= W ? m_d[m_k-1] : (m_p && m_k == W + 1) ? pb : 1'b1;
      end
    end
  end

  always @(negedge clk) if (m_ok) begin
    chk("model_tx", {31'b0, tx}, {31'b0, e_tx});
    chk("model_busy", {31'b0, busy}, {31'b0, e_busy});
  end

  logic [31:0] got, gotb;
  int nb;

  // accepts on the next edge, then records n line samples starting with the start bit
  task automatic frame(input logic [W-1:0] d, input logic p, input int n, input int mode);
    got = 0; gotb = 0; nb = 0;
    pd = d; pe = p; dv = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) dv = (mode == 4);
      if (mode == 3 && i == 1) pb = 1'b1;
      if (mode == 4 && i == 0) pd = 8'h00;
      if (mode == 4 && i == 11) dv = 1'b0;
      if (mode == 5) begin
        pd = 8'h7E; pe = ~pe; dv = (i < 8);
      end
      got = {got[30:0], tx};
      gotb = {gotb[30:0], busy};
      nb += busy;
    end
    dv = 1'b0; pe = 1'b0;
  endtask

  task automatic wait_idle;
    int c = 0;
    while (busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; dv = 1'b1; pd = 8'h5A; pe = 1'b0; pb = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0; dv = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    frame(8'hA5, 1'b0, 12, 2);
    chk("a5_seq", got, {20'b0, 10'b0101001011, 2'b11});
    chk("a5_busy", nb, 10);

    frame(8'h3C, 1'b1, 13, 3);
    chk("3c_seq", got, {19'b0, 11'b00011110011, 2'b11});
    chk("3c_busy", nb, 11);
    pb = 1'b0;

    frame(8'hFF, 1'b0, 23, 4);
    chk("b2b_seq", got, {9'b0, 21'b011111111110000000001, 2'b11});
    chk("b2b_busy", gotb, {9'b0, 21'b111111111101111111111, 2'b00});

    frame(8'h81, 1'b1, 13, 5);
    chk("81_seq", got, {19'b0, 11'b01000000101, 2'b11});
    chk("81_busy", nb, 11);
    wait_idle();

    pd = 8'hA5; pe = 1'b0; dv = 1'b1;
    got = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) dv = 1'b0;
      got = {got[30:0], tx};
      if (i == 3) rst = 1'b1;
    end
    chk("abort_head", got, 32'b0101);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", {31'b0, tx}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    frame(8'h5A, 1'b0, 12, 6);
    chk("5a_seq", got, {20'b0, 10'b0010110101, 2'b11});
    chk("5a_busy", nb, 10);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      dv = ($urandom_range(0, 3) != 0);
      pd = W'($urandom);
      pe = 1'($urandom);
      pb = 1'($urandom);
    end
    rst = 1'b0; dv = 1'b0;
    repeat (15) @(negedge clk);
    chk("final_idle", {30'b0, busy, tx}, 32'b01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
